pipeline_arbiter: RTL and testbench

//  Shares one registered valid/ready pipeline stage among N upstream requesters.

---
 rtl/pipeline_arbiter_pkg.sv | 21 ++
 rtl/pipeline_arbiter_slice.sv | 53 +++++
 rtl/pipeline_arbiter.sv | 109 ++++++++++
 tb/tb_pipeline_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_arbiter_pkg.sv
// Shared helpers for pipeline_arbiter: select-width derivation and lock-state encoding.
package pipeline_arbiter_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A single requester still needs a 1-bit select so the port never collapses to zero width.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/pipeline_arbiter_slice.sv
// Two-entry registered valid/ready stage (main + skid); ready depends only on local state.
module pipeline_arbiter_slice #(
  parameter int pw = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [pw-1:0] in_payload,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [pw-1:0] out_payload,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [pw-1:0] main_q;
  logic [pw-1:0] skid_q;
  logic          main_valid;
  logic          skid_valid;
  logic          unload;
  logic          accept;

  assign in_ready    = !skid_valid && !reset;
  assign out_payload = main_q;
  assign out_valid   = main_valid;
  assign unload      = main_valid && out_ready;
  assign accept      = in_valid && in_ready;

  // A full skid blocks intake, so skid refill and skid drain never coincide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (unload) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || unload) begin
        main_q     <= in_payload;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= in_payload;
        skid_valid <= 1'b1;
      end
    end else if (unload) begin
      main_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_arbiter.sv
// Round-robin N:1 arbiter feeding a main+skid output stage with a {sel, data} tag.
// Burst locking on up_last is enabled by defining PIPELINE_ARBITER_LOCK_EN.
module pipeline_arbiter
  import pipeline_arbiter_pkg::*;
#(
  parameter  int width = 8,
  parameter  int n_req = 4,
  localparam int sel_w = sel_width(n_req)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [n_req*width-1:0] up_data,
  input  logic [n_req-1:0]       up_valid,
  input  logic [n_req-1:0]       up_last,
  output logic [n_req-1:0]       up_ready,
  output logic [width-1:0]       down_data,
  output logic [sel_w-1:0]       down_sel,
  output logic                   down_valid,
  input  logic                   down_ready
);

  logic [sel_w-1:0] rr_ptr;
  logic [sel_w-1:0] winner;
  logic [sel_w-1:0] cand;
  logic [sel_w-1:0] next_ptr;
  logic [width-1:0] win_data;
  logic             any_valid;
  logic             slice_ready;
  logic             accept;

`ifdef PIPELINE_ARBITER_LOCK_EN
  lock_state_t      lock_state;
  logic [sel_w-1:0] lock_idx;
`else
  logic             unused_last;
  assign unused_last = ^up_last;
`endif

  // Scan from the farthest offset down so the nearest valid index from rr_ptr wins.
  always_comb begin
    winner    = rr_ptr;
    cand      = '0;
    any_valid = 1'b0;
    for (int i = n_req - 1; i >= 0; i--) begin
      cand = sel_w'((int'(rr_ptr) + i) % n_req);
      if (up_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
`ifdef PIPELINE_ARBITER_LOCK_EN
    if (lock_state == LOCKED) begin
      winner    = lock_idx;
      any_valid = up_valid[lock_idx];
    end
`endif
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < n_req; i++) begin
      if (winner == sel_w'(i)) win_data = up_data[i*width +: width];
    end
  end

  always_comb begin
    up_ready = '0;
    if (accept) up_ready[winner] = 1'b1;
  end

  assign accept   = any_valid && slice_ready;
  assign next_ptr = sel_w'((int'(winner) + 1) % n_req);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
`ifdef PIPELINE_ARBITER_LOCK_EN
      lock_state <= UNLOCKED;
      lock_idx   <= '0;
`endif
    end else if (accept) begin
`ifdef PIPELINE_ARBITER_LOCK_EN
      if (up_last[winner]) begin
        rr_ptr     <= next_ptr;
        lock_state <= UNLOCKED;
      end else begin
        lock_state <= LOCKED;
        lock_idx   <= winner;
      end
`else
      rr_ptr <= next_ptr;
`endif
    end
  end

  pipeline_arbiter_slice #(
    .pw(sel_w + width)
  ) u_slice (
    .clock      (clock),
    .reset      (reset),
    .in_payload ({winner, win_data}),
    .in_valid   (any_valid),
    .in_ready   (slice_ready),
    .out_payload({down_sel, down_data}),
    .out_valid  (down_valid),
    .out_ready  (down_ready)
  );

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Bench for pipeline_arbiter: queue-based reference model checked every cycle, plus directed literals.
module tb_pipeline_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] up_data;
  logic [3:0]  up_valid;
  logic [3:0]  up_last;
  logic [3:0]  up_ready;
  logic [7:0]  down_data;
  logic [1:0]  down_sel;
  logic        down_valid;
  logic        down_ready;

  int tests = 0;
  int fails = 0;

  pipeline_arbiter #(.width(8), .n_req(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .up_data   (up_data),
    .up_valid  (up_valid),
    .up_last   (up_last),
    .up_ready  (up_ready),
    .down_data (down_data),
    .down_sel  (down_sel),
    .down_valid(down_valid),
    .down_ready(down_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output buffer is just an ordered list of up to two beats.
  logic [9:0] m_q[$];
  int         m_rr = 0;
  bit         m_locked = 0;
  int         m_lock = 0;
  int         m_wait[4];
  int         m_w;
  logic [3:0] m_ready;

  function automatic int m_winner(input logic [3:0] v);
    if (m_locked) return v[m_lock] ? m_lock : -1;
    for (int k = 0; k < 4; k++) begin
      if (v[(m_rr + k) % 4]) return (m_rr + k) % 4;
    end
    return -1;
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_down_valid", {31'd0, down_valid}, 32'd0);
      chk("rst_up_ready", {28'd0, up_ready}, 32'd0);
      chk("rst_down_data", {24'd0, down_data}, 32'd0);
      chk("rst_down_sel", {30'd0, down_sel}, 32'd0);
      m_q.delete();
      m_rr = 0;
      m_locked = 0;
      m_lock = 0;
      for (int i = 0; i < 4; i++) m_wait[i] = 0;
    end else begin
      chk("m_down_valid", {31'd0, down_valid}, {31'd0, m_q.size() > 0});
      if (m_q.size() > 0) begin
        chk("m_down_data", {24'd0, down_data}, {24'd0, m_q[0][7:0]});
        chk("m_down_sel", {30'd0, down_sel}, {30'd0, m_q[0][9:8]});
      end
      m_w = m_winner(up_valid);
      m_ready = (m_w >= 0 && m_q.size() < 2) ? (4'b0001 << m_w) : 4'b0000;
      chk("m_up_ready", {28'd0, up_ready}, {28'd0, m_ready});
`ifndef PIPELINE_ARBITER_LOCK_EN
      for (int i = 0; i < 4; i++) begin
        if (up_valid[i] && m_ready[i]) begin
          chk("no_starve", m_wait[i], (m_wait[i] < 4) ? m_wait[i] : 3);
          m_wait[i] = 0;
        end else if (up_valid[i] && m_ready != 0) begin
          m_wait[i]++;
        end else if (!up_valid[i]) begin
          m_wait[i] = 0;
        end
      end
`endif
      if (m_q.size() > 0 && down_ready) void'(m_q.pop_front());
      if (m_ready != 0) begin
        m_q.push_back({m_w[1:0], up_data[m_w*8 +: 8]});
`ifdef PIPELINE_ARBITER_LOCK_EN
        if (up_last[m_w]) begin
          m_locked = 0;
          m_rr = (m_w + 1) % 4;
        end else begin
          m_locked = 1;
          m_lock = m_w;
        end
`else
        m_rr = (m_w + 1) % 4;
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    up_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    up_valid = '0;
    up_last = '1;
    down_ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  logic [3:0] acc;
  int         cnt[4];
  logic [1:0] exp_sel[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    reset = 1'b1;
    up_data = '0;
    up_valid = '0;
    up_last = '1;
    down_ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;

    // Single requester 2, then rr_ptr should point at 3.
    up_valid = 4'b0100;
    set_data(2, 8'hA5);
    @(negedge clock);
    chk("req2_ready", {28'd0, up_ready}, 32'h4);
    cyc();
    up_valid = 4'b0000;
    @(negedge clock);
    chk("req2_valid", {31'd0, down_valid}, 32'd1);
    chk("req2_data", {24'd0, down_data}, 32'hA5);
    chk("req2_sel", {30'd0, down_sel}, 32'd2);
    cyc();
    up_valid = 4'b1111;
    @(negedge clock);
    chk("rr_after_req2", {28'd0, up_ready}, 32'h8);
    cyc();
    up_valid = 4'b0000;
    cyc();

    // All valid, full throughput rotation.
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
    up_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k >= 1) begin
        chk("rot_sel", {30'd0, down_sel}, {30'd0, exp_sel[k-1]});
        chk("rot_data", {24'd0, down_data}, {24'd0, 8'h10 + 8'(exp_sel[k-1])});
      end
      cyc();
    end
    up_valid = 4'b0000;
    cyc();
    cyc();

    // Backpressure: three stalled clocks while req0 streams 1,2,3.
    do_reset();
    down_ready = 1'b0;
    up_valid = 4'b0001;
    set_data(0, 8'd1);
    @(negedge clock);
    chk("bp_ready1", {31'd0, up_ready[0]}, 32'd1);
    cyc();
    set_data(0, 8'd2);
    @(negedge clock);
    chk("bp_ready2", {31'd0, up_ready[0]}, 32'd1);
    cyc();
    set_data(0, 8'd3);
    @(negedge clock);
    chk("bp_ready3", {31'd0, up_ready[0]}, 32'd0);
    cyc();
    down_ready = 1'b1;
    @(negedge clock);
    chk("bp_out1", {24'd0, down_data}, 32'd1);
    chk("bp_ready4", {31'd0, up_ready[0]}, 32'd0);
    cyc();
    @(negedge clock);
    chk("bp_out2", {24'd0, down_data}, 32'd2);
    chk("bp_ready5", {31'd0, up_ready[0]}, 32'd1);
    cyc();
    up_valid = 4'b0000;
    @(negedge clock);
    chk("bp_out3", {24'd0, down_data}, 32'd3);
    chk("bp_valid3", {31'd0, down_valid}, 32'd1);
    cyc();
    @(negedge clock);
    chk("bp_empty", {31'd0, down_valid}, 32'd0);
    cyc();

    // Reset with the skid full, then first grant must go to req0.
    do_reset();
    down_ready = 1'b0;
    up_valid = 4'b1111;
    cyc();
    cyc();
    @(negedge clock);
    chk("skid_full_ready", {28'd0, up_ready}, 32'd0);
    cyc();
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_valid", {31'd0, down_valid}, 32'd0);
    chk("midrst_ready", {28'd0, up_ready}, 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_grant", {28'd0, up_ready}, 32'h1);
    cyc();
    up_valid = 4'b0000;
    down_ready = 1'b1;
    repeat (3) cyc();

`ifdef PIPELINE_ARBITER_LOCK_EN
    // Burst lock: req1 three beats with a gap; others must wait.
    do_reset();
    up_last = 4'b1111;
    up_valid = 4'b0001;
    cyc();
    up_valid = 4'b1011;
    up_last = 4'b1101;
    set_data(1, 8'hB1);
    @(negedge clock);
    chk("lock_b1", {28'd0, up_ready}, 32'h2);
    cyc();
    up_valid = 4'b1001;
    @(negedge clock);
    chk("lock_gap", {28'd0, up_ready}, 32'h0);
    cyc();
    up_valid = 4'b1011;
    set_data(1, 8'hB2);
    @(negedge clock);
    chk("lock_b2", {28'd0, up_ready}, 32'h2);
    cyc();
    up_last = 4'b1111;
    set_data(1, 8'hB3);
    @(negedge clock);
    chk("lock_b3", {28'd0, up_ready}, 32'h2);
    cyc();
    @(negedge clock);
    chk("lock_release", {28'd0, up_ready}, 32'h8);
    cyc();
    up_valid = 4'b0000;
    repeat (3) cyc();
`endif

    // Random soak with per-source sequence-numbered data.
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clock);
      acc = up_valid & up_ready;
      cyc();
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) cnt[i]++;
        set_data(i, {2'(i), 6'(cnt[i])});
      end
      up_valid = 4'($urandom_range(0, 15));
      up_last = 4'($urandom_range(0, 15));
      down_ready = ($urandom_range(0, 3) != 0);
    end
    up_valid = 4'b0000;
    down_ready = 1'b1;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
